// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked carry-select adder.
// Chunk count and index width are derived from the WIDTH/CHUNK parameters of the top.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // NCHUNK >= 2 is required, so $clog2 never yields 0 in legal configurations.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;
  localparam int DEF_IDX_W = idx_width(nchunk(DEF_WIDTH, DEF_CHUNK));

endpackage

// File: rtl/csel_chunk.sv
// One carry-select slice: two CHUNK-bit adders (carry-in 0 and 1) and a per-bit 2:1 select.
// Purely combinational; res = {carry_out, sum[CHUNK-1:0]}.
module csel_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             sel,
  output logic [CHUNK:0]   res
);

  logic [CHUNK:0] s0;
  logic [CHUNK:0] s1;

  assign s0 = {1'b0, a} + {1'b0, b};
  assign s1 = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, 1'b1};

  always_comb begin
    res = '0;
    for (int i = 0; i <= CHUNK; i++) begin
      res[i] = sel ? s1[i] : s0[i];
    end
  end

endmodule

// File: rtl/csel_add_seq.sv
// Multi-cycle chunked carry-select adder: one WIDTH-bit add per accepted start,
// CHUNK bits per cycle LSB first. Handshake: start is sampled only in IDLE; done pulses for one cycle.
module csel_add_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK:0]   sel_res;

  assign a_c = a_q[int'(idx)*CHUNK +: CHUNK];
  assign b_c = b_q[int'(idx)*CHUNK +: CHUNK];

  csel_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a   (a_c),
    .b   (b_c),
    .sel (carry_q),
    .res (sel_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum[int'(idx)*CHUNK +: CHUNK] <= sel_res[CHUNK-1:0];
          carry_q <= sel_res[CHUNK];
          idx     <= idx + IW'(1);
          if (idx == LAST) begin
            cout  <= sel_res[CHUNK];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
